symm_norm_ctrl: RTL
===================

# symm_norm_ctrl

Sequencer for the symmetric-normalization stage of the FastICA core. It drives the `SYMM_NORM` datapath through repeated passes: square, then row-sum. Each pass reduces the four row sums to a maximum, tests it against unity, and hands the maximum to an external scale unit (divide / inverse-sqrt) over a req/ack handshake. It stops when the matrix is normalized or an iteration cap is reached. It sits between the top-level ICA sequencer (start/done) and the `SYMM_NORM` / squarer / scaler datapath.

## Interface
Parameters:
- `W`, 26: datapath word width, signed.
- `FRAC`, 20: fractional bits; unity = `1 << FRAC`.
- `TOL`, 64: convergence tolerance in LSBs.
- `MAX_ITER`, 8: maximum scale passes, ≥ 1.
- `SQ_LAT`, 2: squarer pipeline latency in cycles, ≥ 1.
- `TIMEOUT`, 255: scale-ack watchdog limit (see Configuration).

Ports:
- `clk_norm` in 1: the single clock.
- `rst_norm` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin normalization.
- `sum1`..`sum4` in W (signed, each): row sums registered by `SYMM_NORM`.
- `scale_ack` in 1: scale unit accepted `scale_val` and finished rewriting the matrix.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle completion pulse.
- `converged` out 1: valid with `done`, held until the next `start`.
- `err` out 1: sticky error, cleared by the next accepted `start`.
- `iter_cnt` out 4: number of completed scale passes.
- `sq_start` out 1: one-cycle pulse that launches the squarer.
- `en_norm` out 1: one-cycle enable to `SYMM_NORM`.
- `scale_req` out 1: request to the scale unit.
- `scale_val` out W: maximum row sum; stable while `scale_req` is high.

## Operation
- States: IDLE, SQUARE, SUM, CAPT, CHECK, SCALE, DONE.
- **IDLE**
  - `start` with no error pending moves to SQUARE.
  - On that transition: `iter_cnt` ← 0, `err` ← 0, `converged` ← 0.
  - `start` in any other state is ignored.
- **SQUARE**
  - Lasts exactly `SQ_LAT` cycles.
  - `sq_start` is high in the first cycle only.
  - Then moves to SUM.
- **SUM**: one cycle, `en_norm` = 1, then CAPT.
- **CAPT**: one cycle.
  - Registers `max_q` = signed maximum of `sum1`..`sum4`.
  - If any sum is negative (a sum of squares has overflowed), sets `err` and moves to DONE.
  - Otherwise moves to CHECK.
- **CHECK**: one cycle.
  - If |`max_q` − unity| ≤ `TOL`: `converged` ← 1, move to DONE.
  - Else if `iter_cnt` == `MAX_ITER`: move to DONE with `converged` = 0.
  - Else move to SCALE.
  - The difference is computed at W+1 bits so the comparison cannot wrap.
- **SCALE**
  - `scale_req` = 1 and `scale_val` = `max_q` until `scale_ack` is sampled high.
  - On that edge: `iter_cnt` increments, `scale_req` drops, move to SQUARE.
  - `scale_ack` outside SCALE is ignored.
- **DONE**: one cycle, `done` = 1, then IDLE.
- Reset, including mid-operation:
  - State goes to IDLE.
  - All outputs go to 0, including `scale_val`, `iter_cnt`, `err`, `converged`.
  - An in-flight scale request is dropped with no ack expected.

## Timing
- Call the edge that samples `start` E0.
- `busy` rises in cycle 1.
- SQUARE occupies cycles 1..`SQ_LAT`.
- SUM is in cycle `SQ_LAT`+1, CAPT in `SQ_LAT`+2, CHECK in `SQ_LAT`+3.
- If the first check converges, `done` is high in cycle `SQ_LAT`+4. That is cycle 6 at the default `SQ_LAT`.
- Each SCALE pass adds (cycles to ack) + `SQ_LAT` + 3.
- `scale_ack` high in the first SCALE cycle gives a one-cycle SCALE.
- `busy` falls in the cycle after DONE.
- Every output is registered; no input reaches an output through combinational logic.

## Configuration
- `SYMM_NORM_CTRL_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts SCALE cycles.
  - When it reaches `TIMEOUT` without `scale_ack`: `scale_req` drops, `err` ← 1, move to DONE with `converged` = 0.
  - The counter clears on entry to SCALE.
- Macro not defined: SCALE waits indefinitely, with no watchdog logic.

## Structure
- Shared package `symm_norm_pkg`:
  - state enum
  - `W`/`FRAC` defaults
  - unity constant
  - signed max-of-four function
- Optional sub-module `max4_signed`: a combinational comparator tree used by CAPT. Everything else is one FSM module.

## Test plan
- **Converge first pass**
  - Stimulus: all sums = 0x100000 (1.0), `start` at E0.
  - Required: `en_norm` in cycle 3; `done` in cycle 6; `converged` = 1; `iter_cnt` = 0; no `scale_req`.
- **Two scale passes**
  - Stimulus: sums max = 0x180000 on pass 0, 0x110000 on pass 1, 0x100020 on pass 2; `scale_ack` two cycles after each `scale_req`.
  - Required: `scale_val` 0x180000 then 0x110000; `converged` = 1; `iter_cnt` = 2.
- **Iteration cap**
  - Stimulus: `MAX_ITER` = 3, sums fixed at 0x200000.
  - Required: exactly 3 `scale_req` handshakes; `done` with `converged` = 0; `iter_cnt` = 3.
- **Overflow**
  - Stimulus: `sum3` = −5.
  - Required: `err` = 1 after CAPT; `done` in cycle 5; no `scale_req`.
- **Reset mid-SCALE and busy `start`**
  - Stimulus: `rst_norm` asserted while `scale_req` = 1; separately, `start` pulsed while `busy`.
  - Required:
    - After reset, all outputs are 0 and state is IDLE.
    - The extra `start` has no effect.
    - A new `start` after reset runs normally.
- **Timeout** (macro defined, `TIMEOUT` = 10)
  - Stimulus: never ack.
  - Required: `scale_req` drops after 10 cycles; `err` = 1; `done` pulses.

Source files
------------

// File: rtl/symm_norm_pkg.sv
// Shared types and constants for the symmetric-normalization sequencer.
// Holds the FSM state enum, datapath defaults and the signed max-of-four selector.
package symm_norm_pkg;

  localparam int unsigned W_DEF    = 26;
  localparam int unsigned FRAC_DEF = 20;
  localparam int unsigned MAXW     = 64;

  localparam logic signed [W_DEF-1:0] UNITY_DEF = 26'sh010_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQUARE,
    S_SUM,
    S_CAPT,
    S_CHECK,
    S_SCALE,
    S_DONE
  } state_e;

  // Returns the index of the largest of four signed words; the caller
  // sign-extends narrower words to MAXW before calling.
  function automatic logic [1:0] max4_sel(input logic signed [MAXW-1:0] a,
                                          input logic signed [MAXW-1:0] b,
                                          input logic signed [MAXW-1:0] c,
                                          input logic signed [MAXW-1:0] d);
    logic                   s_ab, s_cd;
    logic signed [MAXW-1:0] m_ab, m_cd;
    s_ab = (b > a);
    m_ab = s_ab ? b : a;
    s_cd = (d > c);
    m_cd = s_cd ? d : c;
    if (m_cd > m_ab) return {1'b1, s_cd};
    else             return {1'b0, s_ab};
  endfunction

endpackage

// File: rtl/symm_norm_ctrl_max4.sv
// Combinational signed maximum of four row sums, used when capturing the pass maximum.
module max4_signed
  import symm_norm_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [W-1:0] c_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [W-1:0] max_o
);

  logic signed [MAXW-1:0] a_x, b_x, c_x, d_x;
  logic [1:0]             sel;

  assign a_x = {{(MAXW-W){a_i[W-1]}}, a_i};
  assign b_x = {{(MAXW-W){b_i[W-1]}}, b_i};
  assign c_x = {{(MAXW-W){c_i[W-1]}}, c_i};
  assign d_x = {{(MAXW-W){d_i[W-1]}}, d_i};

  assign sel = max4_sel(a_x, b_x, c_x, d_x);

  always_comb begin
    max_o = a_i;
    case (sel)
      2'd0: max_o = a_i;
      2'd1: max_o = b_i;
      2'd2: max_o = c_i;
      2'd3: max_o = d_i;
      default: max_o = a_i;
    endcase
  end

endmodule

// File: rtl/symm_norm_ctrl.sv
// Sequencer for the FastICA symmetric-normalization stage (square, row-sum, max, scale).
// Define SYMM_NORM_CTRL_TIMEOUT_EN to add the scale-ack watchdog.
module symm_norm_ctrl
  import symm_norm_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned FRAC     = FRAC_DEF,
  parameter int unsigned TOL      = 64,
  parameter int unsigned MAX_ITER = 8,
  parameter int unsigned SQ_LAT   = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk_norm,
  input  logic                rst_norm,
  input  logic                start,
  input  logic signed [W-1:0] sum1,
  input  logic signed [W-1:0] sum2,
  input  logic signed [W-1:0] sum3,
  input  logic signed [W-1:0] sum4,
  input  logic                scale_ack,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic                err,
  output logic [3:0]          iter_cnt,
  output logic                sq_start,
  output logic                en_norm,
  output logic                scale_req,
  output logic signed [W-1:0] scale_val
);

  if (MAX_ITER < 1 || MAX_ITER > 15 || SQ_LAT < 1 || TIMEOUT < 1 ||
      TIMEOUT > 255 || FRAC + 2 > W || W >= MAXW) begin : g_param_chk
    $error("symm_norm_ctrl: parameter out of range");
  end

  localparam int unsigned     WX       = W + 1;
  localparam int unsigned     SQW      = (SQ_LAT > 1) ? $clog2(SQ_LAT) : 1;
  localparam logic [SQW-1:0]  SQ_LOAD  = SQW'(SQ_LAT - 1);
  localparam logic [3:0]      ITER_CAP = 4'(MAX_ITER);
  localparam logic [W:0]      TOL_X    = WX'(TOL);
  localparam logic signed [W:0] UNITY_X = {{(W-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

  state_e              state_q, state_d;
  logic [SQW-1:0]      sq_cnt_q, sq_cnt_d;
  logic signed [W-1:0] max_q, max_d, max_c;
  logic [3:0]          iter_q, iter_d;
  logic                err_q, err_d;
  logic                conv_q, conv_d;
  logic signed [W-1:0] val_q, val_d;
  logic                busy_q, done_q, sq_start_q, en_q, req_q;
  logic                any_neg;
  logic signed [W:0]   diff;
  logic [W:0]          adiff;
  logic                within_tol;

`ifdef SYMM_NORM_CTRL_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
`endif

  max4_signed #(.W(W)) u_max4 (
    .a_i   (sum1),
    .b_i   (sum2),
    .c_i   (sum3),
    .d_i   (sum4),
    .max_o (max_c)
  );

  // A negative row sum means a sum of squares wrapped in the datapath.
  assign any_neg    = sum1[W-1] | sum2[W-1] | sum3[W-1] | sum4[W-1];
  assign diff       = {max_q[W-1], max_q} - UNITY_X;
  assign adiff      = diff[W] ? -diff : diff;
  assign within_tol = (adiff <= TOL_X);

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    max_d    = max_q;
    iter_d   = iter_q;
    err_d    = err_q;
    conv_d   = conv_q;
    val_d    = val_q;
`ifdef SYMM_NORM_CTRL_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SQUARE;
          sq_cnt_d = SQ_LOAD;
          iter_d   = '0;
          err_d    = 1'b0;
          conv_d   = 1'b0;
        end
      end
      S_SQUARE: begin
        if (sq_cnt_q == '0) state_d  = S_SUM;
        else                sq_cnt_d = sq_cnt_q - 1'b1;
      end
      S_SUM: state_d = S_CAPT;
      S_CAPT: begin
        max_d = max_c;
        if (any_neg) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (within_tol) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_q == ITER_CAP) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SCALE;
          val_d   = max_q;
`ifdef SYMM_NORM_CTRL_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_SCALE: begin
        if (scale_ack) begin
          iter_d   = iter_q + 4'd1;
          state_d  = S_SQUARE;
          sq_cnt_d = SQ_LOAD;
        end
`ifdef SYMM_NORM_CTRL_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pulse outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_norm) begin
    if (rst_norm) begin
      state_q    <= S_IDLE;
      sq_cnt_q   <= '0;
      max_q      <= '0;
      iter_q     <= '0;
      err_q      <= 1'b0;
      conv_q     <= 1'b0;
      val_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sq_start_q <= 1'b0;
      en_q       <= 1'b0;
      req_q      <= 1'b0;
`ifdef SYMM_NORM_CTRL_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sq_cnt_q   <= sq_cnt_d;
      max_q      <= max_d;
      iter_q     <= iter_d;
      err_q      <= err_d;
      conv_q     <= conv_d;
      val_q      <= val_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      sq_start_q <= (state_d == S_SQUARE) && (state_q != S_SQUARE);
      en_q       <= (state_d == S_SUM);
      req_q      <= (state_d == S_SCALE);
`ifdef SYMM_NORM_CTRL_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign err       = err_q;
  assign iter_cnt  = iter_q;
  assign sq_start  = sq_start_q;
  assign en_norm   = en_q;
  assign scale_req = req_q;
  assign scale_val = val_q;

endmodule
